// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Coin-return side of the vending path. Pays back a refund given
//            in 5-unit credits, one coin per handshake with the dispenser
//            mechanism, preferring dimes. Keeps a nickel/dime inventory
//            (refill pulses in, dispensed coins out) and reports refunds that
//            could not be fully paid.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1      clock, all logic on rising edge
//   rst           in   1      synchronous reset, active-high
//   refund_req_i  in   1      refund request, sampled only when idle
//   refund_amt_i  in   AMT_W  refund amount in nickel units, taken with req
//   coin_ack_i    in   1      mechanism took the offered coin
//   load_nickel_i in   1      one nickel added to the tube this cycle
//   load_dime_i   in   1      one dime added to the tube this cycle
//   coin_out_o    out  2      offered coin: 00 none, 01 nickel, 10 dime
//   coin_valid_o  out  1      coin_out_o valid, held until coin_ack_i
//   busy_o        out  1      refund in progress
//   done_o        out  1      1-cycle pulse, refund finished
//   short_o       out  1      1-cycle pulse with done_o, change not fully paid
//   remain_out_o  out  AMT_W  unpaid units of the last refund
//   nickel_cnt_o  out  CNT_W  nickel inventory
//   dime_cnt_o    out  CNT_W  dime inventory
// ============================================================================
module change_dispenser #(
   parameter int AMT_W       = 4,
   parameter int CNT_W       = 6,
   parameter int NICKEL_INIT = 10,
   parameter int DIME_INIT   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refund_req_i,
   input  logic [AMT_W-1:0] refund_amt_i,
   input  logic             coin_ack_i,
   input  logic             load_nickel_i,
   input  logic             load_dime_i,
   output logic [1:0]       coin_out_o,
   output logic             coin_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             short_o,
   output logic [AMT_W-1:0] remain_out_o,
   output logic [CNT_W-1:0] nickel_cnt_o,
   output logic [CNT_W-1:0] dime_cnt_o
);

   // Coin codes shared with the coin-accept side; 11 is never driven.
   localparam logic [1:0]       C_COIN_NONE   = 2'b00;
   localparam logic [1:0]       C_COIN_NICKEL = 2'b01;
   localparam logic [1:0]       C_COIN_DIME   = 2'b10;

   localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] C_NICKEL_INIT = CNT_W'(NICKEL_INIT);
   localparam logic [CNT_W-1:0] C_DIME_INIT   = CNT_W'(DIME_INIT);
   localparam logic [AMT_W-1:0] C_AMT_ONE     = AMT_W'(1);
   localparam logic [AMT_W-1:0] C_AMT_TWO     = AMT_W'(2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_OFFER  = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t           state_q;
   logic [AMT_W-1:0] rem_q;
   logic [1:0]       coin_out_q;
   logic             coin_valid_q;
   logic             busy_q;
   logic             done_q;
   logic             short_q;
   logic [AMT_W-1:0] remain_q;
   logic [CNT_W-1:0] nickel_q;
   logic [CNT_W-1:0] nickel_d;
   logic [CNT_W-1:0] dime_q;
   logic [CNT_W-1:0] dime_d;

   // A coin leaves the tube on the edge where the mechanism acks it.
   // coin_valid_q is always set in OFFER, so the state alone qualifies ack.
   logic ack_take;
   logic take_nickel;
   logic take_dime;

   assign ack_take    = (state_q == S_OFFER) && coin_ack_i;
   assign take_nickel = ack_take && (coin_out_q == C_COIN_NICKEL);
   assign take_dime   = ack_take && (coin_out_q == C_COIN_DIME);

   // ------------------------------------------------------------------------
   // Inventory next-state. A refill and a dispense of the same coin type in
   // one cycle cancel. Refills saturate. A dispense never underflows because
   // a coin is only offered while its count is non-zero, and the count cannot
   // drop while that coin is on offer.
   // ------------------------------------------------------------------------
   always_comb begin
      nickel_d = nickel_q;
      if (load_nickel_i && !take_nickel) begin
         if (nickel_q != C_CNT_MAX) begin
            nickel_d = nickel_q + 1'b1;
         end
      end else if (!load_nickel_i && take_nickel) begin
         nickel_d = nickel_q - 1'b1;
      end
   end

   always_comb begin
      dime_d = dime_q;
      if (load_dime_i && !take_dime) begin
         if (dime_q != C_CNT_MAX) begin
            dime_d = dime_q + 1'b1;
         end
      end else if (!load_dime_i && take_dime) begin
         dime_d = dime_q - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Refund FSM with registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rem_q        <= '0;
         coin_out_q   <= C_COIN_NONE;
         coin_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
         remain_q     <= '0;
         nickel_q     <= C_NICKEL_INIT;
         dime_q       <= C_DIME_INIT;
      end else begin
         nickel_q <= nickel_d;
         dime_q   <= dime_d;
         // done/short are single-cycle pulses on IDLE entry
         done_q   <= 1'b0;
         short_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (refund_req_i) begin
                  rem_q    <= refund_amt_i;
                  remain_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SELECT;
               end
            end

            S_SELECT: begin
               if (rem_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if ((rem_q >= C_AMT_TWO) && (dime_q != '0)) begin
                  // greedy: a dime whenever it does not overpay
                  coin_out_q   <= C_COIN_DIME;
                  coin_valid_q <= 1'b1;
                  state_q      <= S_OFFER;
               end else if (nickel_q != '0) begin
                  coin_out_q   <= C_COIN_NICKEL;
                  coin_valid_q <= 1'b1;
                  state_q      <= S_OFFER;
               end else begin
                  // nothing payable is left in the tubes
                  done_q   <= 1'b1;
                  short_q  <= 1'b1;
                  remain_q <= rem_q;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end

            S_OFFER: begin
               if (coin_ack_i) begin
                  rem_q        <= rem_q - ((coin_out_q == C_COIN_DIME) ? C_AMT_TWO : C_AMT_ONE);
                  coin_out_q   <= C_COIN_NONE;
                  coin_valid_q <= 1'b0;
                  state_q      <= S_GAP;
               end
            end

            S_GAP: begin
               // one idle cycle lets the mechanism settle before the next coin
               state_q <= S_SELECT;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign coin_out_o   = coin_out_q;
   assign coin_valid_o = coin_valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign short_o      = short_q;
   assign remain_out_o = remain_q;
   assign nickel_cnt_o = nickel_q;
   assign dime_cnt_o   = dime_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser. Stimulus pushes the
//            expected coins and refund outcome into queues; an independent
//            monitor pops and compares as the design presents coins and done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

   localparam int AMT_W = 4;
   localparam int CNT_W = 6;
   localparam int NI    = 10;
   localparam int DI    = 10;
   localparam int CMAX  = 63;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             refund_req_i = 1'b0;
   logic [AMT_W-1:0] refund_amt_i = '0;
   logic             coin_ack_i = 1'b0;
   logic             load_nickel_i = 1'b0;
   logic             load_dime_i = 1'b0;
   logic [1:0]       coin_out_o;
   logic             coin_valid_o;
   logic             busy_o;
   logic             done_o;
   logic             short_o;
   logic [AMT_W-1:0] remain_out_o;
   logic [CNT_W-1:0] nickel_cnt_o;
   logic [CNT_W-1:0] dime_cnt_o;

   change_dispenser #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .NICKEL_INIT(NI), .DIME_INIT(DI)
   ) dut (
      .clk(clk), .rst(rst),
      .refund_req_i(refund_req_i), .refund_amt_i(refund_amt_i),
      .coin_ack_i(coin_ack_i),
      .load_nickel_i(load_nickel_i), .load_dime_i(load_dime_i),
      .coin_out_o(coin_out_o), .coin_valid_o(coin_valid_o),
      .busy_o(busy_o), .done_o(done_o), .short_o(short_o),
      .remain_out_o(remain_out_o),
      .nickel_cnt_o(nickel_cnt_o), .dime_cnt_o(dime_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sh;
      int rem;
      int n;
      int d;
   } done_t;

   int    exp_coin[$];
   done_t exp_done[$];
   int    mn = NI;
   int    md = DI;
   int    checks = 0;
   int    errors = 0;
   bit    ack_en = 1'b0;
   int    max_hold = 3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // Reference model: greedy payout is "as many dimes as fit and exist,
   // then nickels as far as they go"; whatever is left is unpaid.
   task automatic push_refund(input int amt);
      int    nd, nn, r;
      done_t e;
      nd = amt / 2;
      if (nd > md) nd = md;
      r  = amt - 2 * nd;
      nn = (r < mn) ? r : mn;
      r  = r - nn;
      for (int i = 0; i < nd; i++) exp_coin.push_back(2);
      for (int i = 0; i < nn; i++) exp_coin.push_back(1);
      md    = md - nd;
      mn    = mn - nn;
      e.sh  = (r != 0) ? 1 : 0;
      e.rem = r;
      e.n   = mn;
      e.d   = md;
      exp_done.push_back(e);
   endtask

   task automatic issue(input int amt);
      @(negedge clk);
      refund_req_i = 1'b1;
      refund_amt_i = AMT_W'(amt);
      @(negedge clk);
      refund_req_i = 1'b0;
      refund_amt_i = AMT_W'($urandom);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_timeout"}, done_o, 1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!coin_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid_timeout"}, coin_valid_o, 1);
   endtask

   task automatic refund(input int amt);
      push_refund(amt);
      issue(amt);
      wait_done("refund");
   endtask

   task automatic load(input int nn, input int nd);
      int k = (nn > nd) ? nn : nd;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         load_nickel_i = (i < nn);
         load_dime_i   = (i < nd);
         if (i < nn && mn < CMAX) mn++;
         if (i < nd && md < CMAX) md++;
      end
      @(negedge clk);
      load_nickel_i = 1'b0;
      load_dime_i   = 1'b0;
   endtask

   // Mechanism model: acks each offered coin after a random hold; also
   // throws in stray acks while nothing is offered, which must be ignored.
   initial begin
      int hold = 0;
      forever begin
         @(negedge clk);
         if (!ack_en) continue;
         if (coin_ack_i) begin
            coin_ack_i = 1'b0;
         end else if (coin_valid_o) begin
            if (hold > 0) begin
               hold--;
            end else begin
               coin_ack_i = 1'b1;
               hold = $urandom_range(0, max_hold);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            coin_ack_i = 1'b1;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      bit         prev_v = 1'b0;
      logic [1:0] prev_c = 2'b00;
      done_t      e;
      int         c;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            continue;
         end
         if (!coin_valid_o) chk("idle_coin_out", coin_out_o, 0);
         if (coin_valid_o && !prev_v) begin
            if (exp_coin.size() == 0) begin
               fail("unexpected_coin");
            end else begin
               c = exp_coin.pop_front();
               chk("coin_code", coin_out_o, c);
            end
         end else if (coin_valid_o && prev_v) begin
            chk("coin_stable", coin_out_o, prev_c);
         end
         if (short_o && !done_o) fail("short_without_done");
         if (done_o) begin
            chk("busy_at_done", busy_o, 0);
            if (exp_done.size() == 0) begin
               fail("unexpected_done");
            end else begin
               e = exp_done.pop_front();
               chk("short", short_o, e.sh);
               chk("remain_out", remain_out_o, e.rem);
               chk("nickel_cnt", nickel_cnt_o, e.n);
               chk("dime_cnt", dime_cnt_o, e.d);
            end
         end
         prev_v = coin_valid_o;
         prev_c = coin_out_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      done_t e;
      // ---------------- reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_coin_valid", coin_valid_o, 0);
      chk("rst_coin_out", coin_out_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_short", short_o, 0);
      chk("rst_remain", remain_out_o, 0);
      chk("rst_nickel", nickel_cnt_o, NI);
      chk("rst_dime", dime_cnt_o, DI);
      rst = 1'b0;
      mn = NI;
      md = DI;
      ack_en = 1'b1;

      // ---------------- 1: refund 3 -> dime then nickel
      refund(3);
      chk("t1_nickel", nickel_cnt_o, 9);
      chk("t1_dime", dime_cnt_o, 9);

      // ---------------- 2: zero refund, no coin, busy exactly one cycle
      push_refund(0);
      @(negedge clk);
      refund_req_i = 1'b1;
      refund_amt_i = '0;
      @(negedge clk);
      refund_req_i = 1'b0;
      chk("t2_busy_first", busy_o, 1);
      chk("t2_no_valid", coin_valid_o, 0);
      chk("t2_no_early_done", done_o, 0);
      @(negedge clk);
      chk("t2_done", done_o, 1);
      chk("t2_busy_off", busy_o, 0);
      @(negedge clk);
      chk("t2_done_pulse", done_o, 0);

      // ---------------- 4: stalled offer, mid-refund requests ignored
      ack_en = 1'b0;
      push_refund(3);
      issue(3);
      wait_valid("t4");
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         refund_req_i = i[0];
         refund_amt_i = AMT_W'($urandom);
      end
      @(negedge clk);
      refund_req_i = 1'b0;
      chk("t4_still_busy", busy_o, 1);
      chk("t4_still_valid", coin_valid_o, 1);
      ack_en = 1'b1;
      wait_done("t4");
      repeat (6) @(negedge clk);
      chk("t4_idle_after", busy_o, 0);

      // ---------------- 5: dime refill on the dime-ack edge, then saturation
      ack_en = 1'b0;
      exp_coin.push_back(2);
      e.sh = 0; e.rem = 0; e.n = mn; e.d = md;
      exp_done.push_back(e);
      issue(2);
      wait_valid("t5");
      coin_ack_i  = 1'b1;
      load_dime_i = 1'b1;
      @(negedge clk);
      coin_ack_i  = 1'b0;
      load_dime_i = 1'b0;
      wait_done("t5");
      chk("t5_dime_unchanged", dime_cnt_o, md);
      load(0, 64);
      chk("t5_dime_sat", dime_cnt_o, CMAX);
      load(60, 0);
      chk("t5_nickel_sat", nickel_cnt_o, CMAX);

      // ---------------- 6: reset during OFFER
      push_refund(4);
      issue(4);
      wait_valid("t6");
      rst = 1'b1;
      @(negedge clk);
      chk("t6_valid", coin_valid_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_done", done_o, 0);
      chk("t6_nickel", nickel_cnt_o, NI);
      chk("t6_dime", dime_cnt_o, DI);
      rst = 1'b0;
      mn = NI;
      md = DI;
      exp_coin.delete();
      exp_done.delete();
      @(negedge clk);
      chk("t6_no_done", done_o, 0);
      ack_en = 1'b1;
      refund(2);
      chk("t6_one_dime", dime_cnt_o, DI - 1);
      chk("t6_nickels_kept", nickel_cnt_o, NI);

      // ---------------- 3: drain to dime=0/nickel=2, then short payout
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mn = NI;
      md = DI;
      refund(15);
      refund(6);
      refund(7);
      chk("t3_pre_dime", dime_cnt_o, 0);
      chk("t3_pre_nickel", nickel_cnt_o, 2);
      refund(5);
      chk("t3_short_flag", short_o, 1);
      chk("t3_remain", remain_out_o, 3);
      chk("t3_nickel", nickel_cnt_o, 0);
      repeat (4) @(negedge clk);
      chk("t3_remain_held", remain_out_o, 3);
      refund(1);
      chk("t3_empty_remain", remain_out_o, 1);

      // ---------------- randomized phase
      for (int i = 0; i < 60; i++) begin
         max_hold = $urandom_range(0, 4);
         if ($urandom_range(0, 2) == 0) begin
            load($urandom_range(0, 6), $urandom_range(0, 6));
         end else begin
            refund($urandom_range(0, 15));
         end
      end

      repeat (5) @(negedge clk);
      chk("leftover_coins", exp_coin.size(), 0);
      chk("leftover_done", exp_done.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
